// File: rtl/mul_pkg.sv
// Purpose: shared definitions for the sequential Booth multiplier and the decoder that drives its mode.
// Latency: none (package only).
// Backpressure: n/a.
// Contents: signedness mode constants, FSM state encoding, iteration-count helper, signedness decode.
package mul_pkg;

  // Signedness selection; 2'b11 is reserved and decodes like MUL_UU.
  localparam logic [1:0] MUL_SS = 2'b00;  // op1 signed,   op2 signed
  localparam logic [1:0] MUL_SU = 2'b01;  // op1 signed,   op2 unsigned
  localparam logic [1:0] MUL_UU = 2'b10;  // op1 unsigned, op2 unsigned

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Number of accumulate iterations: ceil(G / UNROLL) with G = (WIDTH+2)/2 Booth groups.
  function automatic int mul_iters(input int width, input int unroll);
    int groups;
    groups = (width + 2) / 2;
    return (groups + unroll - 1) / unroll;
  endfunction

  function automatic logic op1_is_signed(input logic [1:0] mode);
    return (mode == MUL_SS) || (mode == MUL_SU);
  endfunction

  function automatic logic op2_is_signed(input logic [1:0] mode);
    return (mode == MUL_SS);
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Purpose: radix-4 Booth recoder producing one partial product from a 3-bit multiplier group.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: grp_i  - {y[2k+1], y[2k], y[2k-1]} multiplier group
//        x_i    - extended multiplicand X (W2 bits, two's complement)
//        pp_o   - partial product, ones' complemented when negative (W2+1 bits)
//        neg_o  - carry-in that completes the two's-complement negation
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int W2 = 34
) (
  input  logic [2:0]    grp_i,
  input  logic [W2-1:0] x_i,
  output logic [W2:0]   pp_o,
  output logic          neg_o
);

  logic [W2:0] mag;

  always_comb begin
    mag   = '0;
    neg_o = 1'b0;
    case (grp_i)
      3'b001, 3'b010: mag = {x_i[W2-1], x_i};   // +X
      3'b011:         mag = {x_i, 1'b0};        // +2X
      3'b100: begin                              // -2X
        mag   = {x_i, 1'b0};
        neg_o = 1'b1;
      end
      3'b101, 3'b110: begin                      // -X
        mag   = {x_i[W2-1], x_i};
        neg_o = 1'b1;
      end
      default: ;                                 // 000 / 111 -> 0, no carry-in
    endcase
    // -M is formed as ~M + 1; the +1 rides into the accumulator adder via neg_o.
    pp_o = neg_o ? ~mag : mag;
  end

endmodule

// File: rtl/mul_booth_seq.sv
// Purpose: iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU) retiring UNROLL groups per clock.
// Latency: out_valid rises N = ceil(((WIDTH+2)/2)/UNROLL) edges after the accept edge.
// Backpressure: one request in flight; result held in DONE until out_ready, in_ready low meanwhile.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_op1/in_op2/in_mode request side;
//        out_valid/out_ready/out_res result side; busy high while BUSY or DONE.
module mul_booth_seq
  import mul_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_op1,
  input  logic [WIDTH-1:0]     in_op2,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_res,
  output logic                 busy
);

  localparam int W2 = WIDTH + 2;
  localparam int G  = W2 / 2;
  localparam int AW = 2 * W2;
  localparam int N  = mul_iters(WIDTH, UNROLL);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mul_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [W2-1:0]   x_q;          // extended multiplicand
  logic [W2:0]     y_q;          // extended multiplier with the implicit y[-1] = 0 appended at bit 0
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   acc_d;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [2:0]      grp_w [UNROLL];
  logic [W2:0]     pp_w  [UNROLL];
  logic [UNROLL-1:0] neg_w;

  // Group k of this iteration is k = cnt*UNROLL + j; groups beyond G-1 read as 000.
  always_comb begin
    for (int j = 0; j < UNROLL; j++) begin
      if (int'(cnt_q) * UNROLL + j < G) begin
        grp_w[j] = 3'(y_q >> (2 * (int'(cnt_q) * UNROLL + j)));
      end else begin
        grp_w[j] = 3'b000;
      end
    end
  end

  for (genvar j = 0; j < UNROLL; j++) begin : g_pp
    booth_pp_gen #(
      .W2(W2)
    ) u_pp (
      .grp_i (grp_w[j]),
      .x_i   (x_q),
      .pp_o  (pp_w[j]),
      .neg_o (neg_w[j])
    );
  end

  // Each partial product is sign-extended to the accumulator width and placed at weight 4^k,
  // together with its negate carry-in; the whole sum collapses into one carry-propagate adder.
  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < UNROLL; j++) begin
      acc_d = acc_d
            + ({{(AW-W2-1){pp_w[j][W2]}}, pp_w[j]} << (2 * (int'(cnt_q) * UNROLL + j)))
            + ({{(AW-1){1'b0}}, neg_w[j]}          << (2 * (int'(cnt_q) * UNROLL + j)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            x_q <= op1_is_signed(in_mode) ? {{2{in_op1[WIDTH-1]}}, in_op1} : {2'b00, in_op1};
            y_q <= op2_is_signed(in_mode) ? {{2{in_op2[WIDTH-1]}}, in_op2, 1'b0}
                                          : {2'b00, in_op2, 1'b0};
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= ST_BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_BUSY: begin
          acc_q <= acc_d;
          if (cnt_q == CW'(N - 1)) begin
            cnt_q       <= '0;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          // acc_q is not written here, so out_res holds through any stall.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  // Low 2*WIDTH bits of the wider accumulator are the exact product modulo 2^(2*WIDTH).
  assign out_res   = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_mul_booth_seq.sv
// Purpose: self-checking bench for mul_booth_seq (WIDTH=32, UNROLL=4) against an arithmetic model.
// Latency: expects out_valid 5 edges after accept.
// Backpressure: exercises out_ready stalls with pending requests, resets in BUSY and DONE.
module tb_mul_booth_seq;

  localparam int WIDTH  = 32;
  localparam int UNROLL = 4;
  localparam int NITER  = 5;   // ceil(17/4)

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_op1;
  logic [WIDTH-1:0]  in_op2;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] out_res;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_booth_seq #(
    .WIDTH  (WIDTH),
    .UNROLL (UNROLL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .busy      (busy)
  );

  // Reference: extend each operand by its mode's signedness, multiply exactly, keep 64 bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] m);
    logic signed [65:0] ea;
    logic signed [65:0] eb;
    logic signed [65:0] p;
    ea = (m == 2'b00 || m == 2'b01) ? {{34{a[31]}}, a} : {34'd0, a};
    eb = (m == 2'b00) ? {{34{b[31]}}, b} : {34'd0, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full request/response. gap: idle cycles before issuing; stall: cycles out_ready stays
  // low after out_valid; pend: drive a competing in_valid during the stall.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        input int gap, input int stall, input bit pend, input string tag);
    logic [63:0] exp;
    int cyc;
    int w;
    exp = ref_mul(a, b, m);
    repeat (gap) @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op1   = a;
    in_op2   = b;
    in_mode  = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_op1   = $urandom;
    in_op2   = $urandom;
    in_mode  = 2'($urandom);
    check({tag, " busy"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check({tag, " latency"}, 64'(cyc), 64'(NITER));
    check({tag, " result"}, out_res, exp);
    for (int i = 0; i < stall; i++) begin
      if (pend) begin
        in_valid = 1'b1;
        in_op1   = $urandom;
        in_op2   = $urandom;
        in_mode  = 2'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold_res"}, out_res, exp);
      check({tag, " hold_vld"}, 64'(out_valid), 64'd1);
      check({tag, " hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, " retire_vld"}, 64'(out_valid), 64'd0);
    check({tag, " retire_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] corners [5];
    logic [31:0] ra;
    logic [31:0] rb;
    bit          seen;
    int          w;
    corners = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op1    = '0;
    in_op2    = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset out_res", out_res, 64'd0);
    rst = 1'b0;

    // Corner products in each mode.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1, 0, 1'b0, "ss_m1xm1");
    check("ss_m1xm1 const", out_res, 64'h0000_0000_0000_0001);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 0, 0, 1'b0, "uu_max");
    check("uu_max const", out_res, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 0, 0, 1'b0, "su_max");
    check("su_max const", out_res, 64'hFFFF_FFFF_0000_0001);
    run_op(32'h8000_0000, 32'h8000_0000, 2'b00, 0, 0, 1'b0, "ss_min");
    check("ss_min const", out_res, 64'h4000_0000_0000_0000);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 0, 0, 1'b0, "reserved_mode");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 0, 0, 1'b0, "su_min");

    // Backpressure: 10-cycle stall with a competing request, then back-to-back accept.
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 0, 10, 1'b1, "bp_stall");
    run_op(32'h0000_0003, 32'h0000_0005, 2'b10, 0, 0, 1'b0, "bp_next");

    // Reset during BUSY, with a simultaneous request that must be ignored.
    in_valid = 1'b1;
    in_op1   = 32'h0BAD_F00D;
    in_op2   = 32'h1357_9BDF;
    in_mode  = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_busy out_valid", 64'(out_valid), 64'd0);
    check("rst_busy in_ready", 64'(in_ready), 64'd1);
    check("rst_busy busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("rst_busy no_result", 64'(seen), 64'd0);
    run_op(32'd7, 32'hFFFF_FFFD, 2'b00, 0, 0, 1'b0, "post_rst");
    check("post_rst const", out_res, 64'hFFFF_FFFF_FFFF_FFEB);

    // Reset during DONE, outranking a simultaneous out_ready handshake.
    in_valid = 1'b1;
    in_op1   = 32'hDEAD_BEEF;
    in_op2   = 32'h0000_0010;
    in_mode  = 2'b10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("rst_done reached", 64'(out_valid), 64'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    check("rst_done out_valid", 64'(out_valid), 64'd0);
    check("rst_done in_ready", 64'(in_ready), 64'd1);
    check("rst_done out_res", out_res, 64'd0);

    // Random sweep with random gaps/stalls, corner-biased operands and all four mode codes.
    for (int n = 0; n < 1000; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      run_op(ra, rb, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
